// File: rtl/sram_responder.sv
// Memory-side responder for the external data-memory bus: async read, clocked write,
// self-clearing sweep after reset/clear. Optional write protection: SRAM_RESPONDER_WPROT_EN.
module sram_responder #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = 8'h00,
  parameter logic [ADDR_WIDTH-1:0] PROTECT_BASE = 8'hF0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic                  sram_write_en,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  input  logic                  clr_req,
  output logic                  mem_ready,
  output logic [7:0]            wr_count,
  output logic [ADDR_WIDTH-1:0] last_wr_addr,
  output logic                  prot_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_sweep_cnt;
  logic                  r_mem_ready;
  logic [7:0]            r_wr_count;
  logic [ADDR_WIDTH-1:0] r_last_wr_addr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_accept;
  logic                  w_wr_allowed;
  logic                  w_oe;

`ifdef SRAM_RESPONDER_WPROT_EN
  logic r_prot_err;
  logic w_prot_hit;

  assign w_wr_allowed = (sram_addr < PROTECT_BASE);
  assign w_prot_hit   = (r_state == ST_READY) & ~clr_req & sram_write_en & ~w_wr_allowed;
  assign prot_err     = r_prot_err;

  // Sticky protect-violation flag, cleared only by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prot_err <= 1'b0;
    end else if (w_prot_hit) begin
      r_prot_err <= 1'b1;
    end else begin
      r_prot_err <= r_prot_err;
    end
  end
`else
  logic w_unused_prot_base;

  assign w_unused_prot_base = &{1'b0, PROTECT_BASE};
  assign w_wr_allowed       = 1'b1;
  assign prot_err           = 1'b0;
`endif

  // Next state and memory write-port selection: the sweep owns the port during INIT.
  always_comb begin
    w_next_state = r_state;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_sweep_cnt;
    w_mem_wdata  = INIT_VALUE;
    w_accept     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_mem_we = 1'b1;
        if (r_sweep_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
          w_next_state = ST_READY;
        end else begin
          w_next_state = ST_INIT;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          w_next_state = ST_INIT;
        end else if (sram_write_en && w_wr_allowed) begin
          w_next_state = ST_READY;
          w_mem_we     = 1'b1;
          w_mem_addr   = sram_addr;
          w_mem_wdata  = sram_data;
          w_accept     = 1'b1;
        end else begin
          w_next_state = ST_READY;
        end
      end
      default: begin
        w_next_state = ST_INIT;
      end
    endcase
  end

  // State register, sweep counter and readiness flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_sweep_cnt <= {ADDR_WIDTH{1'b0}};
      r_mem_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_mem_ready <= (w_next_state == ST_READY);
      if (r_state == ST_INIT) begin
        r_sweep_cnt <= r_sweep_cnt + ADDR_WIDTH'(1);
      end else begin
        r_sweep_cnt <= {ADDR_WIDTH{1'b0}};
      end
    end
  end

  // Write statistics; kept across clear sweeps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_count     <= 8'h00;
      r_last_wr_addr <= {ADDR_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_last_wr_addr <= sram_addr;
      if (r_wr_count != 8'hFF) begin
        r_wr_count <= r_wr_count + 8'h01;
      end else begin
        r_wr_count <= r_wr_count;
      end
    end else begin
      r_wr_count     <= r_wr_count;
      r_last_wr_addr <= r_last_wr_addr;
    end
  end

  // Storage array: contents are defined only once the sweep has run.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Release the bus the instant the core starts writing, so it is never contended.
  assign w_oe      = r_mem_ready & ~sram_write_en;
  assign sram_data = w_oe ? r_mem[sram_addr] : {DATA_WIDTH{1'bz}};

  assign mem_ready    = r_mem_ready;
  assign wr_count     = r_wr_count;
  assign last_wr_addr = r_last_wr_addr;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: random bus traffic against a behavioural memory model.
module tb_sram_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sram_addr = 8'h00;
  logic       sram_write_en = 1'b0;
  logic       clr_req = 1'b0;
  logic [7:0] tb_dat = 8'h00;
  wire  [7:0] sram_data;
  logic       mem_ready;
  logic [7:0] wr_count;
  logic [7:0] last_wr_addr;
  logic       prot_err;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0] m_mem [256];
  bit         m_ready;
  int         m_sweep_left;
  int         m_count;
  logic [7:0] m_last;
  bit         m_prot;

  assign sram_data = sram_write_en ? tb_dat : 8'bzzzzzzzz;

  always #5 clk = ~clk;

  sram_responder dut (
    .clk          (clk),
    .rst          (rst),
    .sram_addr    (sram_addr),
    .sram_write_en(sram_write_en),
    .sram_data    (sram_data),
    .clr_req      (clr_req),
    .mem_ready    (mem_ready),
    .wr_count     (wr_count),
    .last_wr_addr (last_wr_addr),
    .prot_err     (prot_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic bit is_protected(input logic [7:0] a);
`ifdef SRAM_RESPONDER_WPROT_EN
    return (a >= 8'hF0);
`else
    return (a != a);
`endif
  endfunction

  function automatic void model_reset();
    m_ready      = 1'b0;
    m_sweep_left = 256;
    m_count      = 0;
    m_last       = 8'h00;
    m_prot       = 1'b0;
  endfunction

  // One rising edge as seen by the system: sweep progress, clear, or an accepted write.
  function automatic void model_edge(input bit we, input logic [7:0] a, input logic [7:0] d,
                                     input bit clr);
    if (!m_ready) begin
      m_sweep_left--;
      if (m_sweep_left == 0) begin
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        m_ready = 1'b1;
      end
    end else if (clr) begin
      m_ready      = 1'b0;
      m_sweep_left = 256;
    end else if (we) begin
      if (is_protected(a)) begin
        m_prot = 1'b1;
      end else begin
        m_mem[a] = d;
        m_last   = a;
        if (m_count < 255) m_count++;
      end
    end
  endfunction

  task automatic step(input bit we, input logic [7:0] a, input logic [7:0] d, input bit clr);
    sram_write_en = we;
    sram_addr     = a;
    tb_dat        = d;
    clr_req       = clr;
    #1;
    if (we) chk("bus_release", sram_data, d);
    @(posedge clk);
    model_edge(we, a, d, clr);
    #1;
    chk("mem_ready", {7'd0, mem_ready}, {7'd0, m_ready});
    chk("wr_count", wr_count, 8'(m_count));
    chk("last_wr_addr", last_wr_addr, m_last);
    chk("prot_err", {7'd0, prot_err}, {7'd0, m_prot});
  endtask

  task automatic rd(input logic [7:0] a);
    sram_write_en = 1'b0;
    clr_req       = 1'b0;
    sram_addr     = a;
    #1;
    chk("read", sram_data, m_mem[a]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_ready", {7'd0, mem_ready}, 8'h00);
    chk("reset_wr_count", wr_count, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Power-up sweep with the core idle
    repeat (256) step(1'b0, 8'($urandom), 8'h00, 1'b0);
    rd(8'h00);
    rd(8'hFF);
    repeat (4) rd(8'($urandom));

    // Directed write then next-cycle read; second write checks bus release over old data
    step(1'b1, 8'h10, 8'hA5, 1'b0);
    rd(8'h10);
    step(1'b1, 8'h10, 8'h5A, 1'b0);
    rd(8'h10);

    // Saturating write counter
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      step(1'b1, a, 8'($urandom), 1'b0);
      rd(a);
    end

    // Random mix of reads and writes
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        step(1'b0, 8'($urandom), 8'h00, 1'b0);
      end else begin
        step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
      end
      rd(8'($urandom));
    end

    // Clear request with a write on the same edge, then traffic during the sweep
    step(1'b1, 8'h20, 8'h3C, 1'b0);
    rd(8'h20);
    step(1'b1, 8'h30, 8'h99, 1'b1);
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      step(1'($urandom), 8'($urandom), d, 1'($urandom));
    end
    rd(8'h20);
    rd(8'h30);
    rd(8'($urandom));

    // Asynchronous reset in the middle of a sweep
    step(1'b0, 8'h00, 8'h00, 1'b1);
    repeat (100) step(1'b0, 8'($urandom), 8'h00, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("midsweep_rst_ready", {7'd0, mem_ready}, 8'h00);
    chk("midsweep_rst_count", wr_count, 8'h00);
    chk("midsweep_rst_last", last_wr_addr, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (256) step(1'b0, 8'($urandom), 8'h00, 1'b0);
    rd(8'h64);
    rd(8'h20);

    // Protected-range boundary (stored normally when protection is compiled out)
    step(1'b1, 8'hF5, 8'h77, 1'b0);
    rd(8'hF5);
    step(1'b1, 8'hEF, 8'h42, 1'b0);
    rd(8'hEF);
    step(1'b1, 8'hF0, 8'h11, 1'b0);
    rd(8'hF0);
    step(1'b0, 8'h00, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
